// File: rtl/imuldiv_muldiv_resp_adapter_pkg.sv
// Shared mul/div definitions: function encodings, default tag width and the
// {fn, tag} layout of a tag-queue entry. Used by imuldiv_muldiv_resp_adapter.
package imuldiv_muldiv_resp_adapter_pkg;

  localparam int FN_BITS          = 3;
  localparam int TAG_BITS_DEFAULT = 5;
  localparam int DATA_BITS        = 32;
  localparam int RESULT_BITS      = 64;

  typedef enum logic [FN_BITS-1:0] {
    FN_MUL  = 3'd0,
    FN_DIV  = 3'd1,
    FN_DIVU = 3'd2,
    FN_REM  = 3'd3,
    FN_REMU = 3'd4
  } muldiv_fn_e;

  // Request message as seen by the iterative unit.
  typedef struct packed {
    logic [FN_BITS-1:0]   fn;
    logic [DATA_BITS-1:0] a;
    logic [DATA_BITS-1:0] b;
  } muldiv_req_msg_t;

  // Queue entry is {fn, tag}: tag occupies the low bits, fn sits directly above.
  localparam int ENTRY_TAG_LSB = 0;

  function automatic int entry_fn_lsb(input int tag_bits);
    return ENTRY_TAG_LSB + tag_bits;
  endfunction

  function automatic int entry_bits(input int tag_bits);
    return tag_bits + FN_BITS;
  endfunction

endpackage

// File: rtl/imuldiv_muldiv_resp_adapter_tagq.sv
// In-order tag queue (imuldiv_RespTagQueue): holds {fn, tag} for every request
// issued to the mul/div unit until its response is consumed.
module imuldiv_RespTagQueue #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [W-1:0]     mem [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full)) else $error("tag queue push while full");
      assert (!(pop && empty)) else $error("tag queue pop while empty");
    end
  end
`endif

endmodule

// File: rtl/imuldiv_muldiv_resp_adapter.sv
// Mul/div response adapter: forwards requests, tracks {fn, tag} in order and
// turns the 64-bit unit result into a tagged 32-bit writeback.
// Optional registered writeback stage: define IMULDIV_RESP_OUTBUF_EN.
module imuldiv_muldiv_resp_adapter
  import imuldiv_muldiv_resp_adapter_pkg::*;
#(
  parameter int TAG_BITS = TAG_BITS_DEFAULT,
  parameter int DEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic [2:0]           in_msg_fn,
  input  logic [31:0]          in_msg_a,
  input  logic [31:0]          in_msg_b,
  input  logic [TAG_BITS-1:0]  in_msg_tag,
  input  logic                 in_val,
  output logic                 in_rdy,

  output logic [2:0]           muldivreq_msg_fn,
  output logic [31:0]          muldivreq_msg_a,
  output logic [31:0]          muldivreq_msg_b,
  output logic                 muldivreq_val,
  input  logic                 muldivreq_rdy,

  input  logic [63:0]          muldivresp_msg_result,
  input  logic                 muldivresp_val,
  output logic                 muldivresp_rdy,

  output logic [31:0]          wb_msg_data,
  output logic [TAG_BITS-1:0]  wb_msg_tag,
  output logic                 wb_val,
  input  logic                 wb_rdy
);

  localparam int ENTRY_W = entry_bits(TAG_BITS);
  localparam int FN_LSB  = entry_fn_lsb(TAG_BITS);

  // REM/REMU live in the upper word; everything else (including unknown codes)
  // uses the lower word.
  function automatic logic [31:0] select_result(input logic [2:0]  fn,
                                                input logic [63:0] result);
    logic [31:0] sel;
    case (fn)
      FN_REM, FN_REMU: sel = result[63:32];
      default:         sel = result[31:0];
    endcase
    return sel;
  endfunction

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head;
  logic [2:0]         head_fn;
  logic [TAG_BITS-1:0] head_tag;
  logic [31:0]        resp_data;

  assign muldivreq_msg_fn = in_msg_fn;
  assign muldivreq_msg_a  = in_msg_a;
  assign muldivreq_msg_b  = in_msg_b;

  // Admission depends on full alone, so a same-cycle pop never frees a slot.
  assign muldivreq_val = in_val && !full;
  assign in_rdy        = muldivreq_rdy && !full;

  assign push       = in_val && in_rdy;
  assign pop        = muldivresp_val && muldivresp_rdy;
  assign push_entry = {in_msg_fn, in_msg_tag};

  imuldiv_RespTagQueue #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_tagq (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign head_fn   = head[FN_LSB +: FN_BITS];
  assign head_tag  = head[ENTRY_TAG_LSB +: TAG_BITS];
  assign resp_data = select_result(head_fn, muldivresp_msg_result);

`ifdef IMULDIV_RESP_OUTBUF_EN
  logic                vld_p1;
  logic [31:0]         data_p1;
  logic [TAG_BITS-1:0] tag_p1;

  assign muldivresp_rdy = !empty && (!vld_p1 || wb_rdy);

  // ---- stage p1: registered writeback buffer ----
  always_ff @(posedge clk) begin
    if (reset)       vld_p1 <= 1'b0;
    else if (pop)    vld_p1 <= 1'b1;
    else if (wb_rdy) vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      data_p1 <= resp_data;
      tag_p1  <= head_tag;
    end
  end

  assign wb_val      = vld_p1;
  assign wb_msg_data = data_p1;
  assign wb_msg_tag  = tag_p1;
`else
  assign muldivresp_rdy = wb_rdy && !empty;
  assign wb_val         = muldivresp_val && !empty;
  assign wb_msg_data    = resp_data;
  assign wb_msg_tag     = head_tag;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(muldivresp_val && empty))
        else $error("mul/div response with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_imuldiv_muldiv_resp_adapter.sv
// Scoreboard bench for imuldiv_muldiv_resp_adapter; the bench plays the mul/div unit.
module tb_imuldiv_muldiv_resp_adapter;
  import imuldiv_muldiv_resp_adapter_pkg::*;

  localparam int TB    = 5;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    in_msg_fn;
  logic [31:0]   in_msg_a;
  logic [31:0]   in_msg_b;
  logic [TB-1:0] in_msg_tag;
  logic          in_val;
  logic          in_rdy;
  logic [2:0]    muldivreq_msg_fn;
  logic [31:0]   muldivreq_msg_a;
  logic [31:0]   muldivreq_msg_b;
  logic          muldivreq_val;
  logic          muldivreq_rdy;
  logic [63:0]   muldivresp_msg_result;
  logic          muldivresp_val;
  logic          muldivresp_rdy;
  logic [31:0]   wb_msg_data;
  logic [TB-1:0] wb_msg_tag;
  logic          wb_val;
  logic          wb_rdy;

  always #5 clk = ~clk;

  imuldiv_muldiv_resp_adapter #(.TAG_BITS(TB), .DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .in_msg_fn             (in_msg_fn),
    .in_msg_a              (in_msg_a),
    .in_msg_b              (in_msg_b),
    .in_msg_tag            (in_msg_tag),
    .in_val                (in_val),
    .in_rdy                (in_rdy),
    .muldivreq_msg_fn      (muldivreq_msg_fn),
    .muldivreq_msg_a       (muldivreq_msg_a),
    .muldivreq_msg_b       (muldivreq_msg_b),
    .muldivreq_val         (muldivreq_val),
    .muldivreq_rdy         (muldivreq_rdy),
    .muldivresp_msg_result (muldivresp_msg_result),
    .muldivresp_val        (muldivresp_val),
    .muldivresp_rdy        (muldivresp_rdy),
    .wb_msg_data           (wb_msg_data),
    .wb_msg_tag            (wb_msg_tag),
    .wb_val                (wb_val),
    .wb_rdy                (wb_rdy)
  );

  int total   = 0;
  int bad     = 0;
  int wb_cnt  = 0;
  int exp_cnt = 0;

  logic [TB+31:0] sb[$];
  logic           hold = 1'b0;
  logic [31:0]    hold_data;
  logic [TB-1:0]  hold_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every writeback handshake and checks that
  // stalled outputs do not move.
  always @(negedge clk) begin
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_val", 64'(wb_val), 64'd1);
        chk("hold_data", 64'(wb_msg_data), 64'(hold_data));
        chk("hold_tag", 64'(wb_msg_tag), 64'(hold_tag));
      end
      if (wb_val && wb_rdy) begin
        wb_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wb_unexpected: got tag=%0d data=%0h expected no writeback",
                   wb_msg_tag, wb_msg_data);
        end else begin
          logic [TB+31:0] e;
          e = sb.pop_front();
          chk("wb_tag", 64'(wb_msg_tag), 64'(e[TB+31:32]));
          chk("wb_data", 64'(wb_msg_data), 64'(e[31:0]));
        end
      end
      hold      = wb_val && !wb_rdy;
      hold_data = wb_msg_data;
      hold_tag  = wb_msg_tag;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the request is taken.
  task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [TB-1:0] tag);
    int n;
    in_msg_fn  = fn;
    in_msg_a   = a;
    in_msg_b   = b;
    in_msg_tag = tag;
    in_val     = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_rdy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("req_accept_in_time", 64'(n < 20), 64'd1);
    chk("req_val", 64'(muldivreq_val), 64'd1);
    chk("req_fn", 64'(muldivreq_msg_fn), 64'(fn));
    chk("req_a", 64'(muldivreq_msg_a), 64'(a));
    chk("req_b", 64'(muldivreq_msg_b), 64'(b));
    @(posedge clk); #1;
    in_val = 1'b0;
  endtask

  // Plays the unit's response; expected writeback goes into the scoreboard.
  task automatic respond(input logic [63:0] res, input logic [31:0] d, input logic [TB-1:0] t);
    int n;
    sb.push_back({t, d});
    exp_cnt++;
    muldivresp_msg_result = res;
    muldivresp_val        = 1'b1;
    n = 0;
    @(negedge clk);
    while (!muldivresp_rdy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("resp_accept_in_time", 64'(n < 20), 64'd1);
`ifndef IMULDIV_RESP_OUTBUF_EN
    chk("wb_latency0", 64'(wb_val), 64'd1);
`endif
    @(posedge clk); #1;
    muldivresp_val = 1'b0;
`ifdef IMULDIV_RESP_OUTBUF_EN
    @(negedge clk);
    chk("wb_latency1", 64'(wb_val), 64'd1);
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   n;
    reset                 = 1'b1;
    in_msg_fn             = '0;
    in_msg_a              = '0;
    in_msg_b              = '0;
    in_msg_tag            = '0;
    in_val                = 1'b0;
    muldivreq_rdy         = 1'b1;
    muldivresp_msg_result = '0;
    muldivresp_val        = 1'b0;
    wb_rdy                = 1'b1;

    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_wb_val", 64'(wb_val), 64'd0);
    chk("rst_resp_rdy", 64'(muldivresp_rdy), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_req_val", 64'(muldivreq_val), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    issue(FN_MUL, 32'd7, 32'd6, 5'd3);
    respond(64'd42, 32'd42, 5'd3);

    issue(FN_REM, 32'd17, 32'd5, 5'd9);
    respond({32'd2, 32'd3}, 32'd2, 5'd9);
    issue(FN_DIV, 32'd17, 32'd5, 5'd9);
    respond({32'd2, 32'd3}, 32'd3, 5'd9);

    // Back-to-back: fill the queue, then a third request must be held off.
    issue(FN_DIVU, 32'd100, 32'd7, 5'd1);
    issue(FN_REMU, 32'd100, 32'd7, 5'd2);
    in_msg_fn  = FN_MUL;
    in_msg_a   = 32'd3;
    in_msg_b   = 32'd4;
    in_msg_tag = 5'd6;
    in_val     = 1'b1;
    @(negedge clk);
    chk("full_in_rdy", 64'(in_rdy), 64'd0);
    chk("full_req_val", 64'(muldivreq_val), 64'd0);
    @(posedge clk); #1;
    in_val = 1'b0;
    respond({32'd2, 32'd14}, 32'd14, 5'd1);
    respond({32'd2, 32'd14}, 32'd2, 5'd2);
    issue(FN_MUL, 32'd3, 32'd4, 5'd6);
    respond(64'd12, 32'd12, 5'd6);

    // Backpressure: writeback stalled for 5 cycles with a response pending.
    issue(FN_MUL, 32'd5, 32'd5, 5'd7);
    sb.push_back({5'd7, 32'd25});
    exp_cnt++;
    wb_rdy                = 1'b0;
    muldivresp_msg_result = 64'd25;
    muldivresp_val        = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        chk("bp_resp_rdy", 64'(muldivresp_rdy), 64'd0);
        chk("bp_wb_val", 64'(wb_val), 64'd1);
      end
      if (muldivresp_rdy) acc = 1'b1;
      @(posedge clk); #1;
      if (acc) muldivresp_val = 1'b0;
    end
    wb_rdy = 1'b1;
    if (!acc) begin
      n = 0;
      @(negedge clk);
      while (!muldivresp_rdy && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("bp_release", 64'(n < 20), 64'd1);
      @(posedge clk); #1;
      muldivresp_val = 1'b0;
    end else begin
      @(negedge clk);
      chk("bp_release_val", 64'(wb_val), 64'd1);
      @(posedge clk); #1;
    end

    // Reset with a request in flight: its tag must be discarded.
    issue(FN_MUL, 32'd9, 32'd9, 5'd4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_wb_val", 64'(wb_val), 64'd0);
    chk("rst2_resp_rdy", 64'(muldivresp_rdy), 64'd0);
    chk("rst2_in_rdy", 64'(in_rdy), 64'd1);
    @(posedge clk); #1;
    issue(FN_MUL, 32'd2, 32'd3, 5'd5);
    respond(64'd6, 32'd6, 5'd5);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("wb_count", 64'(wb_cnt), 64'(exp_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
